// File: rtl/miniproc_pkg.sv
// Shared types and constants for the mini-processor fetch/branch front end.
// Optional RETURN_STACK_EN adds a return-address stack to branch_ctrl.
package miniproc_pkg;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned RAS_AW    = $clog2(RAS_DEPTH);

  localparam logic [PC_W-1:0] RESET_VEC = 16'h0000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT     = 3'd2,
    EVAL     = 3'd3,
    REDIRECT = 3'd4
  } state_t;

  // Branch fields captured when a branch instruction is accepted
  typedef struct packed {
    logic [SEL_W-1:0] flagsel;
    logic             hilo;
    logic [PC_W-1:0]  target;
    logic             call;
    logic             ret;
  } br_fields_t;

  // Out-of-range selectors (3..7) fall back to flag 0
  function automatic logic sel_flag(input logic [FLAG_W-1:0] f,
                                    input logic [SEL_W-1:0]  sel);
    logic bit_v;
    case (sel)
      3'd1:    bit_v = f[1];
      3'd2:    bit_v = f[2];
      default: bit_v = f[0];
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch/branch handshake bundle between datapath (master) and branch_ctrl (slave).
// call_req/ret_req/ras_err are only meaningful when RETURN_STACK_EN is defined.
interface branch_ctrl_if;
  import miniproc_pkg::*;

  logic                instr_valid;
  logic                br_req;
  logic [SEL_W-1:0]    br_flagsel;
  logic                br_hilo;
  logic [PC_W-1:0]     br_target;
  logic [FLAG_W-1:0]   flags;
  logic                stall;
  logic                call_req;
  logic                ret_req;
  logic [PC_W-1:0]     pc;
  logic                fetch_en;
  logic                br_taken;
  logic                flush;
  logic                busy;
  logic                ras_err;

  modport master (
    output instr_valid, br_req, br_flagsel, br_hilo, br_target, flags, stall,
           call_req, ret_req,
    input  pc, fetch_en, br_taken, flush, busy, ras_err
  );

  modport slave (
    input  instr_valid, br_req, br_flagsel, br_hilo, br_target, flags, stall,
           call_req, ret_req,
    output pc, fetch_en, br_taken, flush, busy, ras_err
  );

endinterface

// File: rtl/branch_ctrl_ret_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry; a pop of an empty stack is ignored (the caller flags the underflow).
module ret_stack
  import miniproc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_c,
  output logic            empty,
  output logic            full
);

  localparam int unsigned CNT_W = RAS_AW + 1;

  logic [PC_W-1:0]   mem [RAS_DEPTH];
  logic [RAS_AW-1:0] sp;
  logic [CNT_W-1:0]  count;

  assign top_c = mem[sp - RAS_AW'(1)];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[sp] <= push_data;
    end
  end

  // sp points at the next free slot, which is also the oldest entry when full
  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else if (push) begin
      sp    <= sp + RAS_AW'(1);
      if (!full) begin
        count <= count + CNT_W'(1);
      end
      empty <= 1'b0;
      full  <= (count >= CNT_W'(RAS_DEPTH - 1));
    end else if (pop && !empty) begin
      sp    <= sp - RAS_AW'(1);
      count <= count - CNT_W'(1);
      empty <= (count == CNT_W'(1));
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Fetch/branch sequencer: IDLE -> FETCH -> WAIT -> (EVAL -> REDIRECT) -> FETCH.
// Define RETURN_STACK_EN to add call/return handling through ret_stack.
module branch_ctrl
  import miniproc_pkg::*;
(
  input logic          clk,
  input logic          rst,
  branch_ctrl_if.slave bus
);

  state_t          state;
  br_fields_t      lat;
  logic [PC_W-1:0] pc_q;
  logic            fetch_en_q;
  logic            br_taken_q;
  logic            flush_q;
  logic            busy_q;
  logic            ras_err_q;
  logic            taken_c;
  logic [PC_W-1:0] pc_inc_c;

  // Flags are sampled live in EVAL, not at latch time
  assign taken_c  = (sel_flag(bus.flags, lat.flagsel) == lat.hilo);
  assign pc_inc_c = pc_q + PC_W'(1);

`ifdef RETURN_STACK_EN
  logic            eval_go_c;
  logic            push_c;
  logic            pop_c;
  logic            ras_empty;
  logic            ras_full_unused;
  logic [PC_W-1:0] ras_top_c;

  assign eval_go_c = (state == EVAL) && !bus.stall && taken_c;
  assign push_c    = eval_go_c && lat.call && !lat.ret;
  assign pop_c     = eval_go_c && lat.ret;

  ret_stack u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .pop       (pop_c),
    .push_data (pc_inc_c),
    .top_c     (ras_top_c),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );
`else
  logic unused_ras;
  assign unused_ras = lat.call ^ lat.ret;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= RESET_VEC;
      lat        <= '0;
      fetch_en_q <= 1'b0;
      br_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b1;
      ras_err_q  <= 1'b0;
    end else begin
      fetch_en_q <= 1'b0;
      br_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      ras_err_q  <= 1'b0;
      // busy tracks the state register, so it is only touched on transitions
      if (!bus.stall) begin
        case (state)
          IDLE: begin
            state  <= FETCH;
            busy_q <= 1'b0;
          end
          FETCH: begin
            fetch_en_q <= 1'b1;
            state      <= WAIT;
            busy_q     <= 1'b1;
          end
          WAIT: begin
            if (bus.instr_valid) begin
              if (bus.br_req) begin
                lat.flagsel <= bus.br_flagsel;
                lat.hilo    <= bus.br_hilo;
                lat.target  <= bus.br_target;
                lat.call    <= bus.call_req;
                lat.ret     <= bus.ret_req;
                state       <= EVAL;
              end else begin
                pc_q   <= pc_inc_c;
                state  <= FETCH;
                busy_q <= 1'b0;
              end
            end
          end
          EVAL: begin
            if (taken_c) begin
`ifdef RETURN_STACK_EN
              if (lat.ret) begin
                pc_q      <= ras_empty ? RESET_VEC : ras_top_c;
                ras_err_q <= ras_empty;
              end else begin
                pc_q <= lat.target;
              end
`else
              pc_q <= lat.target;
`endif
              br_taken_q <= 1'b1;
              state      <= REDIRECT;
            end else begin
              pc_q   <= pc_inc_c;
              state  <= FETCH;
              busy_q <= 1'b0;
            end
          end
          REDIRECT: begin
            flush_q <= 1'b1;
            state   <= FETCH;
            busy_q  <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.fetch_en = fetch_en_q;
  assign bus.br_taken = br_taken_q;
  assign bus.flush    = flush_q;
  assign bus.busy     = busy_q;
  assign bus.ras_err  = ras_err_q;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst, with reset sampled only on the rising edge of clk.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 instr_valid  in  1  fetched instruction present this cycle.
REQ-005 br_req  in  1  fetched instruction is a conditional branch; qualified by instr_valid.
REQ-006 br_flagsel  in  3  index of the flag to test; values 3..7 read as flag 0.
REQ-007 br_hilo  in  1  branch-taken polarity: take when the selected flag equals br_hilo.
REQ-008 br_target  in  16  branch destination address.
REQ-009 flags  in  3  ALU flag vector.
REQ-010 stall  in  1  freeze request from the datapath.
REQ-011 call_req, ret_req  in  1 each  call/return qualifiers; used only with RAS_EN.
REQ-012 pc  out  16  current fetch address.
REQ-013 fetch_en  out  1  one-cycle fetch strobe.
REQ-014 br_taken  out  1  one-cycle pulse, active high, when a branch is taken.
REQ-015 flush  out  1  one-cycle pipeline flush pulse.
REQ-016 busy  out  1  high whenever the state is not FETCH.
REQ-017 ras_err  out  1  return-stack underflow pulse; tied 0 without RAS_EN.

Function
REQ-018 SHALL implement the states IDLE, FETCH, WAIT, EVAL and REDIRECT.
REQ-019 IDLE: go to FETCH on the first cycle after rst deasserts.
REQ-020 FETCH: assert fetch_en for one cycle, then go to WAIT.
REQ-021 WAIT, instr_valid=1 and br_req=0: pc <= pc+1, then go to FETCH.
REQ-022 WAIT, instr_valid=1 and br_req=1: latch br_flagsel, br_hilo, br_target, call_req and ret_req, then go to EVAL.
REQ-023 WAIT, instr_valid=0: remain in WAIT with all outputs unchanged.
REQ-024 EVAL: evaluate taken = (flags[sel] == hilo) using flags sampled in EVAL, not at latch time.
REQ-025 EVAL, taken: pc <= target, br_taken=1 for this cycle, then go to REDIRECT.
REQ-026 EVAL, not taken: pc <= pc+1, then go to FETCH.
REQ-027 REDIRECT: assert flush for exactly one cycle, then go to FETCH.
REQ-028 Branch latency SHALL be fixed: instr_valid to redirected fetch_en takes exactly 3 cycles (EVAL, REDIRECT, FETCH).
REQ-029 pc increment SHALL be modulo 2^16: 0xFFFF+1 = 0x0000, with no error flag.
REQ-030 While stall=1, the FSM state, pc and latched fields SHALL hold and fetch_en, br_taken and flush SHALL be 0.
REQ-031 A stall arriving in the same cycle as a transition SHALL win: the transition is deferred until the first cycle with stall=0.
REQ-032 br_req with instr_valid=0 SHALL be ignored.

Reset
REQ-033 When rst=1: state=IDLE, pc=0x0000, fetch_en=0, br_taken=0, flush=0, busy=1, ras_err=0, return stack emptied.
REQ-034 rst SHALL override stall and any in-progress branch: an in-flight EVAL/REDIRECT is abandoned with no flush pulse.

Configuration
REQ-035 SHALL define the macro RETURN_STACK_EN, which adds a 4-entry return-address stack.
REQ-036 With RETURN_STACK_EN, taken branch with call: push the pre-branch pc+1, then jump to target.
REQ-037 With RETURN_STACK_EN, taken branch with ret: pc <= popped entry; br_target is ignored.
REQ-038 With RETURN_STACK_EN, overflow: a push onto a full stack overwrites the oldest entry (circular), silently.
REQ-039 With RETURN_STACK_EN, underflow: a pop of an empty stack sets pc <= 0x0000 and pulses ras_err for one cycle.
REQ-040 Without RETURN_STACK_EN: call_req and ret_req are ignored, ras_err is held at 0, and no stack storage is synthesized.

Structure
REQ-041 SHALL place in shared package miniproc_pkg: the state enum, PC_W=16, RESET_VEC=16'h0000, RAS_DEPTH=4.
REQ-042 SHALL implement the return stack as sub-module ret_stack (push/pop/empty/full), instantiated only under RETURN_STACK_EN.

Verification
REQ-043 Reset then 3 non-branch instructions -> pc goes 0x0000, 0x0001, 0x0002, 0x0003; one fetch_en per instruction; flush never asserted.
REQ-044 pc=0x0010, branch with flagsel=1, hilo=1, flags=3'b010, target=0x0400 -> br_taken pulses in EVAL; flush pulses one cycle later; next fetch_en has pc=0x0400.
REQ-045 Same branch with flags=3'b000 -> no br_taken, no flush; next fetch at 0x0011.
REQ-046 pc=0xFFFF non-branch -> next fetch at 0x0000; stall held 5 cycles during WAIT -> pc and state frozen; resumes on the first cycle with stall=0.
REQ-047 rst asserted during REDIRECT -> flush=0 on the following cycle; pc=0x0000; state=IDLE.
REQ-048 RETURN_STACK_EN: call at 0x0020 to 0x0100, then ret -> pc=0x0021; ret with empty stack -> pc=0x0000 and one-cycle ras_err.
